// File: rtl/mem_access_initiator_if.sv
// -----------------------------------------------------------------------------
// mem_access_initiator_if
//   Valid/ready request + response bundle between the memory-stage initiator
//   and a multi-cycle data memory.
//
//   Request  (master -> slave): req_valid, req_write, req_addr, req_wdata,
//                               req_wstrb
//   Handshake (slave -> master): req_ready
//   Response (slave -> master): rsp_valid, rsp_rdata, rsp_error
// -----------------------------------------------------------------------------
interface mem_access_initiator_if #(
    parameter int WORD = 64
);
    logic            req_valid;
    logic            req_write;
    logic [WORD-1:0] req_addr;
    logic [WORD-1:0] req_wdata;
    logic [7:0]      req_wstrb;
    logic            req_ready;
    logic            rsp_valid;
    logic [WORD-1:0] rsp_rdata;
    logic            rsp_error;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/mem_access_initiator.sv
// -----------------------------------------------------------------------------
// mem_access_initiator
//   Bus-master side of the LEGv8 data-memory interface. Converts the memory
//   stage controls into a single valid/ready request, stalls the datapath
//   until the response arrives, and returns lane-extracted, extended load
//   data. Misaligned or conflicting requests, bus errors and response
//   timeouts are reported with a one-cycle fault pulse.
//
//   Ports:
//     clk, reset_n          clock, synchronous active-low reset
//     mem_read, mem_write   load / store request levels from the datapath
//     address, write_data   byte address, right-aligned store data
//     size, sign_ext        00 byte .. 11 dword; sign-extend loads
//     stall                 combinational hold for the datapath
//     done, fault           registered one-cycle completion / fault pulses
//     read_data             registered load result, held until next load
//     bus                   master modport of mem_access_initiator_if
// -----------------------------------------------------------------------------
module mem_access_initiator #(
    parameter int WORD    = 64,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [WORD-1:0] address,
    input  logic [WORD-1:0] write_data,
    input  logic [1:0]      size,
    input  logic            sign_ext,
    output logic            stall,
    output logic            done,
    output logic            fault,
    output logic [WORD-1:0] read_data,
    mem_access_initiator_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_e;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_e          state_q,     state_d;
    logic            req_valid_q, req_valid_d;
    logic            req_write_q, req_write_d;
    logic [WORD-1:0] req_addr_q,  req_addr_d;
    logic [WORD-1:0] req_wdata_q, req_wdata_d;
    logic [7:0]      req_wstrb_q, req_wstrb_d;
    logic [WORD-1:0] read_data_q, read_data_d;
    logic            done_q,      done_d;
    logic            fault_q,     fault_d;
    logic [7:0]      cnt_q,       cnt_d;
    logic [2:0]      offset_q,    offset_d;
    logic [1:0]      size_q,      size_d;
    logic            sign_q,      sign_d;

    logic            aligned;
    logic            legal_req;
    logic            illegal_req;
    logic [7:0]      size_mask;
    logic [WORD-1:0] shifted;
    logic [WORD-1:0] load_val;

    // Request classification and store lane mask (pure functions of inputs).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        aligned   = 1'b1;
        size_mask = 8'hFF;
        case (size)
            2'b00:   begin aligned = 1'b1;                  size_mask = 8'h01; end
            2'b01:   begin aligned = (address[0] == 1'b0);   size_mask = 8'h03; end
            2'b10:   begin aligned = (address[1:0] == 2'b0); size_mask = 8'h0F; end
            default: begin aligned = (address[2:0] == 3'b0); size_mask = 8'hFF; end
        endcase
        legal_req   = (mem_read ^ mem_write) & aligned;
        // Both controls high is treated exactly like a misaligned access.
        illegal_req = (mem_read & mem_write) | ((mem_read ^ mem_write) & ~aligned);
    end

    // Load lane extraction from the full aligned response dword.
    always_comb begin
        shifted  = bus.rsp_rdata >> {offset_q, 3'b000};
        load_val = shifted;
        case (size_q)
            2'b00:   load_val = {{(WORD-8){sign_q & shifted[7]}},   shifted[7:0]};
            2'b01:   load_val = {{(WORD-16){sign_q & shifted[15]}}, shifted[15:0]};
            2'b10:   load_val = {{(WORD-32){sign_q & shifted[31]}}, shifted[31:0]};
            default: load_val = shifted;
        endcase
    end

    // Next-state logic for the access FSM and all registered outputs.
    always_comb begin
        state_d     = state_q;
        req_valid_d = 1'b0;
        req_write_d = req_write_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_wstrb_d = req_wstrb_q;
        read_data_d = read_data_q;
        done_d      = 1'b0;
        fault_d     = 1'b0;
        cnt_d       = cnt_q;
        offset_d    = offset_q;
        size_d      = size_q;
        sign_d      = sign_q;

        case (state_q)
            S_IDLE: begin
                if (legal_req) begin
                    state_d     = S_REQ;
                    req_valid_d = 1'b1;
                    req_write_d = mem_write;
                    req_addr_d  = {address[WORD-1:3], 3'b000};
                    req_wdata_d = mem_write ? (write_data << {address[2:0], 3'b000}) : '0;
                    req_wstrb_d = mem_write ? (size_mask << address[2:0]) : 8'h00;
                    offset_d    = address[2:0];
                    size_d      = size;
                    // Extension is meaningless for a full dword.
                    sign_d      = sign_ext & (size != 2'b11);
                end else if (illegal_req) begin
                    fault_d = 1'b1;
                end
            end
            S_REQ: begin
                if (bus.req_ready) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    req_valid_d = 1'b1;
                end
            end
            S_WAIT: begin
                // A response on the final timeout cycle still wins.
                if (bus.rsp_valid) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    fault_d = bus.rsp_error;
                    if (!req_write_q) begin
                        read_data_d = bus.rsp_error ? '0 : load_val;
                    end
                end else if (cnt_q == TIMEOUT_CNT) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its pre-edge value regardless of statement order.
        if (!reset_n) begin
            state_q     <= S_IDLE;
            req_valid_q <= 1'b0;
            req_write_q <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_wstrb_q <= 8'h00;
            read_data_q <= '0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            cnt_q       <= '0;
            offset_q    <= '0;
            size_q      <= '0;
            sign_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_valid_q <= req_valid_d;
            req_write_q <= req_write_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_wstrb_q <= req_wstrb_d;
            read_data_q <= read_data_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            cnt_q       <= cnt_d;
            offset_q    <= offset_d;
            size_q      <= size_d;
            sign_q      <= sign_d;
        end
    end

    // Stall is the only combinational output: it must cover the IDLE cycle
    // in which a legal request is first seen.
    assign stall = reset_n & (((state_q == S_IDLE) & legal_req) |
                              (state_q == S_REQ) | (state_q == S_WAIT));

    assign done          = done_q;
    assign fault         = fault_q;
    assign read_data     = read_data_q;
    assign bus.req_valid = req_valid_q;
    assign bus.req_write = req_write_q;
    assign bus.req_addr  = req_addr_q;
    assign bus.req_wdata = req_wdata_q;
    assign bus.req_wstrb = req_wstrb_q;

endmodule

// File: doc/mem_access_initiator.md
# mem_access_initiator

- Bus-master side of the data-memory interface for the LEGv8 datapath.
- Takes the memory-stage control (`mem_read`, `mem_write`, `address`, `write_data`, access size, sign) and turns it into a valid/ready request to a multi-cycle data memory.
- Stalls the datapath until the response returns, then delivers lane-extracted, extended `read_data`.
- Detects misaligned accesses, conflicting controls, bus errors and response timeouts.

## Interface
Parameters:
- `WORD`, 64, datapath and bus data width (bits).
- `TIMEOUT`, 255, max cycles waiting for `rsp_valid` before fault; range 1–255.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  sole clock, all state updates on rising edge.
- `reset_n`  in  1  synchronous active-low reset.
- `mem_read`  in  1  load request (level).
- `mem_write`  in  1  store request (level).
- `address`  in  WORD  byte address.
- `write_data`  in  WORD  store data, right-aligned.
- `size`  in  2  access size: 00 byte, 01 half, 10 word, 11 dword.
- `sign_ext`  in  1  sign-extend loaded data (LDURSW, etc.); ignored for dword and for stores.
- `stall`  out  1  hold datapath while access is pending.
- `done`  out  1  one-cycle pulse when access completes (success or fault).
- `fault`  out  1  one-cycle pulse, coincident with `done` or in place of an access.
- `read_data`  out  WORD  load result; holds until next load completes.
- `req_valid`  out  1  bus request valid.
- `req_write`  out  1  1 = store.
- `req_addr`  out  WORD  `address` with bits [2:0] cleared.
- `req_wdata`  out  WORD  store data shifted to byte lane.
- `req_wstrb`  out  8  byte enables.
- `req_ready`  in  1  memory accepts request.
- `rsp_valid`  in  1  response valid.
- `rsp_rdata`  in  WORD  response data, full aligned dword.
- `rsp_error`  in  1  access error, qualified by `rsp_valid`.

## Operation
- States:
  - IDLE: no access outstanding.
  - REQ: `req_valid` = 1; fields frozen.
  - WAIT: awaiting response; timeout counter runs.
  - DONE: one cycle; `done` = 1.
- IDLE:
  - `mem_read` xor `mem_write` with aligned address: register all request fields, go to REQ.
  - Aligned means low `size`-dependent bits zero: half [0], word [1:0], dword [2:0].
  - Misaligned access: pulse `fault` for one cycle with no bus activity; stay in IDLE.
  - `mem_read` and `mem_write` both high: same handling as misaligned.
- REQ:
  - On `req_ready` = 1, go to WAIT and clear the counter.
  - `req_addr`, `req_write`, `req_wdata`, `req_wstrb` stay stable while `req_valid` is high.
- WAIT:
  - On `rsp_valid` = 1, go to DONE.
  - For a load without error, `read_data` = `rsp_rdata` >> (8·`address[2:0]`), truncated to size, then zero- or sign-extended per `sign_ext`.
  - `rsp_error` = 1: `read_data` set to 0 for loads, `fault` pulses in DONE.
  - Counter reaches `TIMEOUT` with no response: go to DONE, `fault` pulses.
- DONE: go to IDLE next cycle. A still-asserted request is re-sampled only from IDLE; the datapath advances during DONE.
- Store lane/strobe generation:
  - `req_wstrb` = size mask (0x01 / 0x03 / 0x0F / 0xFF) << `address[2:0]`.
  - `req_wdata` = `write_data` << (8·`address[2:0]`).
- Stores ignore `rsp_rdata` and leave `read_data` unchanged.
- `rsp_valid` outside WAIT is ignored.
- `stall` = (IDLE and legal request) or REQ or WAIT. It is 0 in DONE and while `reset_n` = 0.

## Timing
- Reset values: state IDLE; `req_valid` 0; `req_write` 0; `req_addr` 0; `req_wdata` 0; `req_wstrb` 0; `read_data` 0; `done` 0; `fault` 0; counter 0.
- Reset mid-access: next edge forces IDLE, `req_valid` drops, and any late response is ignored.
- Request seen in IDLE at cycle N:
  - `req_valid` rises at N+1.
  - Minimum `req_ready` at N+1 gives WAIT at N+2.
  - Minimum `rsp_valid` at N+2 gives DONE at N+3, with `read_data` valid and `done` high at N+3.
  - Minimum latency is 3 cycles; `stall` is high for N..N+2.
- Illegal request fault: `fault` high at N+1, no `done`, `stall` never asserted.
- Timeout: DONE is reached `TIMEOUT`+1 cycles after entering WAIT.
- All outputs except `stall` are registered.

## Test plan
- Memory preloaded with dword 0 = 63, dword 1 = 42, dword 2 = 128. Dword load from 8, `req_ready`/`rsp_valid` at minimum latency → `req_addr` = 8, `read_data` = 42, `done` at N+3, `stall` high for 3 cycles.
- Store of 0xFF at address 0x13, byte size → `req_addr` = 0x10, `req_wstrb` = 0x08, `req_wdata` = 0xFF000000. Follow with a signed byte load from 0x13 → `read_data` = all ones (−1); the same load unsigned → `read_data` = 255.
- `req_ready` held low 4 cycles then raised → request fields stable throughout, WAIT entered on the ready cycle, `stall` continuous.
- Word load from 0x06 → `fault` pulse, `req_valid` never asserted. Then `mem_read` and `mem_write` both high → `fault` pulse.
- With `TIMEOUT` = 4 and no response → `done` and `fault` at WAIT+5. Separately, `rsp_error` on a load → `read_data` = 0 and `fault` high.
- `reset_n` low during WAIT, then a late `rsp_valid` → IDLE, `req_valid` = 0, `read_data` = 0, no `done`.
